// File: rtl/tog_evt_rx.sv
// tog_evt_rx: receiver for a toggle-encoded event line.
// Detects each transition of t_in and buffers it in a saturating pending counter.
// Pending events are drained by a valid/ready pop, and each pop is acknowledged
// with a toggle on ack_out. A free-running counter tallies every transition seen.
// Optional build macro: TOG_EVT_RX_SYNC_EN adds a 2-flop input synchronizer.
module tog_evt_rx #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t_in,
  input  logic               evt_ready,
  input  logic               ovf_clr,
  output logic               evt_pulse,
  output logic               evt_valid,
  output logic [CNT_W-1:0]   pend_cnt,
  output logic               ack_out,
  output logic               overflow,
  output logic [TOTAL_W-1:0] total_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             t_s;
  logic             load_done;
  logic             t_q;
  logic             primed;
  logic             edge_det;
  logic             pop;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             ack_next;

`ifdef TOG_EVT_RX_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] load_cnt;

  // Two-flop synchronizer plus a counter that marks it as fully loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b00;
      load_cnt <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], t_in};
      if (!load_cnt[1]) load_cnt <= load_cnt + 2'd1;
    end
  end

  assign t_s       = sync_q[1];
  assign load_done = load_cnt[1];
`else
  assign t_s       = t_in;
  assign load_done = 1'b1;
`endif

  // Priming captures the line level once after reset, then tracks it per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q    <= 1'b0;
      primed <= 1'b0;
    end else if (!primed) begin
      if (load_done) begin
        t_q    <= t_s;
        primed <= 1'b1;
      end
    end else begin
      t_q <= t_s;
    end
  end

  assign edge_det  = primed & (t_s ^ t_q);
  assign evt_valid = (pend_cnt != '0);
  assign pop       = evt_valid & evt_ready;

  // FSM state register tracking the occupancy class of the pending counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (edge_det) state_next = (CNT_MAX == CNT_ONE) ? FULL : PEND;
      PEND: begin
        if (pop && !edge_det && pend_cnt == CNT_ONE)         state_next = IDLE;
        else if (edge_det && !pop && pend_cnt == CNT_MAX_M1) state_next = FULL;
      end
      FULL: if (pop && !edge_det) state_next = PEND;
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic: next values for the pending counter, overflow flag and ack toggle.
  always_comb begin
    cnt_next = pend_cnt;
    ovf_next = overflow;
    ack_next = ack_out ^ pop;
    if (ovf_clr) ovf_next = 1'b0;
    if (edge_det && !pop) begin
      if (pend_cnt == CNT_MAX) ovf_next = 1'b1;
      else                     cnt_next = pend_cnt + CNT_ONE;
    end else if (pop && !edge_det) begin
      cnt_next = pend_cnt - CNT_ONE;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_pulse <= 1'b0;
      pend_cnt  <= '0;
      ack_out   <= 1'b0;
      overflow  <= 1'b0;
      total_cnt <= '0;
    end else begin
      evt_pulse <= edge_det;
      pend_cnt  <= cnt_next;
      ack_out   <= ack_next;
      overflow  <= ovf_next;
      if (edge_det) total_cnt <= total_cnt + TOTAL_W'(1);
    end
  end

endmodule

// File: tb/tb_tog_evt_rx.sv
// tb_tog_evt_rx: table-driven directed bench for tog_evt_rx (default build).
module tb_tog_evt_rx;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TOTAL_W = 16;
  localparam int unsigned OUT_W   = 4 + CNT_W + TOTAL_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               t_in;
  logic               evt_ready;
  logic               ovf_clr;
  logic               evt_pulse;
  logic               evt_valid;
  logic [CNT_W-1:0]   pend_cnt;
  logic               ack_out;
  logic               overflow;
  logic [TOTAL_W-1:0] total_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic               t;
    logic               rdy;
    logic               clr;
    logic               pulse;
    logic               valid;
    logic [CNT_W-1:0]   pend;
    logic               ack;
    logic               ovf;
    logic [TOTAL_W-1:0] total;
  } vec_t;

  vec_t vecs[$];

  tog_evt_rx #(.CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .t_in      (t_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .pend_cnt  (pend_cnt),
    .ack_out   (ack_out),
    .overflow  (overflow),
    .total_cnt (total_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] pack_out(logic p, logic v, logic [CNT_W-1:0] c,
                                                logic a, logic o, logic [TOTAL_W-1:0] tot);
    return {p, v, c, a, o, tot};
  endfunction

  task automatic add(input logic t, input logic rdy, input logic clr, input logic p,
                     input logic v, input int c, input logic a, input logic o, input int tot);
    vec_t r;
    r.t = t; r.rdy = rdy; r.clr = clr; r.pulse = p; r.valid = v;
    r.pend = CNT_W'(c); r.ack = a; r.ovf = o; r.total = TOTAL_W'(tot);
    vecs.push_back(r);
  endtask

  task automatic check_out(input string name, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] act;
    act = pack_out(evt_pulse, evt_valid, pend_cnt, ack_out, overflow, total_cnt);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {pulse,valid,pend,ack,ovf,total}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    bit seen;

    // Priming with t_in=1 held across reset, then three spaced toggles.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 1, 2, 0, 0, 2);
    add(1, 0, 0, 0, 1, 2, 0, 0, 2);
    add(0, 0, 0, 1, 1, 3, 0, 0, 3);
    add(0, 0, 0, 0, 1, 3, 0, 0, 3);
    // Drain three, then a ready with nothing pending is ignored.
    add(0, 1, 0, 0, 1, 2, 1, 0, 3);
    add(0, 1, 0, 0, 1, 1, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 1, 0, 3);
    // Toggle every clock 17 times: saturate at 15 and set overflow.
    for (int i = 1; i <= 17; i++)
      add(logic'(i % 2), 0, 0, 1, 1, (i < 15) ? i : 15, 1, logic'(i >= 16), 3 + i);
    add(1, 0, 1, 0, 1, 15, 1, 0, 20);
    // Lost event with ovf_clr in the same clock: set wins.
    add(0, 0, 1, 1, 1, 15, 1, 1, 21);
    add(0, 0, 1, 0, 1, 15, 1, 0, 21);
    // Drain down to 5.
    for (int j = 1; j <= 10; j++)
      add(0, 1, 0, 0, 1, 15 - j, logic'(j % 2 == 0), 0, 21);
    // Edge and pop together: count holds, ack toggles.
    add(1, 1, 0, 1, 1, 5, 0, 0, 22);
    add(0, 0, 0, 1, 1, 6, 0, 0, 23);
    add(1, 0, 0, 1, 1, 7, 0, 0, 24);

    reset = 1'b1; t_in = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_out("reset_state", '0);
    @(negedge clk); reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      t_in = vecs[k].t; evt_ready = vecs[k].rdy; ovf_clr = vecs[k].clr;
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", k), pack_out(vecs[k].pulse, vecs[k].valid, vecs[k].pend,
                                                 vecs[k].ack, vecs[k].ovf, vecs[k].total));
    end

    // Asynchronous reset mid-stream with 7 pending.
    @(negedge clk);
    evt_ready = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1; #1;
    check_out("async_reset", '0);
    @(posedge clk); @(negedge clk); reset = 1'b0;

`ifdef TOG_EVT_RX_SYNC_EN
    for (int w = 0; w < 3; w++) @(posedge clk);
`else
    @(posedge clk);
`endif
    #1;
    check_out("reprime", '0);

    // Bounded wait for the first post-reset pulse to measure its latency.
    @(negedge clk); t_in = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (evt_pulse) begin seen = 1'b1; lat = c; end
    end
    check_val("pulse_seen", int'(seen), 1);
`ifdef TOG_EVT_RX_SYNC_EN
    check_val("pulse_latency", lat, 3);
`else
    check_val("pulse_latency", lat, 1);
`endif
    check_out("after_reprime_evt", pack_out(1'b1, 1'b1, CNT_W'(1), 1'b0, 1'b0, TOTAL_W'(1)));
    @(posedge clk); #1;
    check_val("pulse_width", int'(evt_pulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
